mem_port_arbiter: RTL

Shares the single SRAM-like memory port between instruction fetch and data access, and generates the `i_stall`/`d_stall` signals consumed by the hazard unit. It accepts one outstanding transaction at a time and holds each completed result in a per-side done buffer until the whole pipeline unfreezes (`longest_stall` low). This prevents a frozen requester from re-issuing a request it has already completed.

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like memory port between instruction fetch and data access.
// Only one transaction is in flight at a time. Each completed result is held in
// a per-side done buffer until the whole pipeline unfreezes, so that a frozen
// requester never re-issues a request it has already completed.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration when both
// sides are pending. Without it, data always wins over fetch.

module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              longest_stall,
   // fetch side
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,
   // data side
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   // memory side
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   // Owner encoding of the request register and of the round-robin history.
   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   // Fetches are always full-word reads.
   localparam logic [1:0] SIZE_WORD = 2'd2;

   state_t            state_q, state_d;

   // Request register: captured on IDLE exit, stable until m_data_ok.
   logic              owner_q, owner_d;
   logic              wr_q,    wr_d;
   logic [1:0]        size_q,  size_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Per-side done buffers.
   logic              i_done_q,  i_done_d;
   logic              d_done_q,  d_done_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   // Arbitration results.
   logic              i_pend;
   logic              d_pend;
   logic              grant_any;
   logic              grant_data;

`ifdef ARB_RR_EN
   // Last winner; the other side wins the next tie.
   logic              last_q, last_d;
`endif

   // Decide which side would win if the FSM were in IDLE this cycle.
   always_comb begin
      i_pend    = i_req & ~i_done_q;
      d_pend    = d_req & ~d_done_q;
      grant_any = i_pend | d_pend;
`ifdef ARB_RR_EN
      if (i_pend && d_pend) begin
         grant_data = (last_q == OWN_FETCH);
      end else begin
         grant_data = d_pend;
      end
`else
      grant_data = d_pend;
`endif
   end

   // Next-state logic for the FSM, the request register and the done buffers.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
      last_d    = last_q;
`endif
      // Done flags drop whenever the pipeline advances; a completion below
      // overrides this so that set wins over clear.
      i_done_d  = i_done_q & longest_stall;
      d_done_d  = d_done_q & longest_stall;

      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               state_d = S_ADDR;
               owner_d = grant_data;
`ifdef ARB_RR_EN
               last_d  = grant_data;
`endif
               if (grant_data) begin
                  wr_d    = d_wr;
                  size_d  = d_size;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  wr_d    = 1'b0;
                  size_d  = SIZE_WORD;
                  addr_d  = i_addr;
                  wdata_d = '0;
               end
            end
         end
         S_ADDR: begin
            if (m_addr_ok) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (m_data_ok) begin
               state_d = S_IDLE;
               if (owner_q == OWN_DATA) begin
                  d_rdata_d = m_rdata;
                  d_done_d  = 1'b1;
               end else begin
                  i_rdata_d = m_rdata;
                  i_done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_FETCH;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_RR_EN
         last_q    <= OWN_FETCH;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   // Memory port is driven purely from state and the request register.
   assign m_req   = (state_q == S_ADDR);
   assign m_wr    = wr_q;
   assign m_size  = size_q;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;

   // Requester-facing outputs.
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign i_stall = i_req & ~i_done_q;
   assign d_stall = d_req & ~d_done_q;

endmodule
